// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, slave FSM state type and byte-lane mask helper
// for the ahb_slave_mem responder.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DATA = 3'd1,
        ST_WAIT = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Little-endian byte enables for a 32-bit word; unsupported sizes enable nothing.
    function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
        logic [3:0] m;
        m = 4'b0000;
        case (hsize)
            HSIZE_BYTE: m = 4'b0001 << addr_lo;
            HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: m = 4'b1111;
            default:    m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_ram.sv
// Word memory behind the AHB slave: one byte-enabled write port, one registered
// read port, whole array and read register cleared asynchronously by HRESETn.
module ahb_slave_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 64,
    parameter int IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_WIDTH-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [IDX_WIDTH-1:0]    raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int NLANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < NLANES; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read-before-write on a same-edge collision; the top merges the new lanes.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite single-transfer memory slave: HSEL decode, error check, FSM, forwarding.
// Optional wait states are built only when AHB_SLAVE_WAIT_EN is defined.
//
//  state | meaning
//  IDLE  | no data phase in progress, ready for an address phase
//  DATA  | data phase, hreadyout=1 OKAY; write lanes commit at the end of the cycle
//  WAIT  | wait states before DATA, hreadyout=0 while the counter runs down
//  ERR1  | first error cycle, hreadyout=0 hresp=ERROR
//  ERR2  | second error cycle, hreadyout=1 hresp=ERROR, may accept next transfer
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int SLAVES_NUM  = 4,
    parameter int SLAVE_ID    = 0,
    parameter int MEM_DEPTH   = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [$clog2(SLAVES_NUM)-1:0] HSEL,
    input  logic [ADDR_WIDTH-1:0]         HADDR,
    input  logic                          HWRITE,
    input  logic [2:0]                    HSIZE,
    input  logic [2:0]                    HBURST,
    input  logic [3:0]                    HPROT,
    input  logic [1:0]                    HTRANS,
    input  logic                          HREADY,
    input  logic [DATA_WIDTH-1:0]         HWDATA,
    output logic                          hreadyout,
    output logic                          hresp,
    output logic [DATA_WIDTH-1:0]         HRDATA
);

    localparam int SEL_W  = $clog2(SLAVES_NUM);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int NLANES = DATA_WIDTH / 8;

    localparam logic [SEL_W-1:0]      MY_ID     = SEL_W'(SLAVE_ID);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_LIM = (ADDR_WIDTH-2)'(MEM_DEPTH);

`ifdef AHB_SLAVE_WAIT_EN
    localparam bit USE_WAIT = (WAIT_CYCLES > 0);
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
`else
    localparam bit USE_WAIT = 1'b0;
`endif

    state_t state, state_nx;

    logic [IDX_W-1:0]      a_idx;
    logic                  accept;
    logic                  bad;
    logic                  take;

    logic [IDX_W-1:0]      d_idx;
    logic                  d_write;
    logic [2:0]            d_size;
    logic [1:0]            d_lo;

    logic                  rd_load;
    logic [IDX_W-1:0]      rd_idx;
    logic                  fwd_hit;

    logic                  we;
    logic [NLANES-1:0]     be;
    logic [DATA_WIDTH-1:0] be_bits;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] fwd_mask;
    logic [DATA_WIDTH-1:0] fwd_data;

    logic                  unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    assign a_idx  = HADDR[2 +: IDX_W];
    assign accept = HREADY && (HSEL == MY_ID) && HTRANS[1];
    assign bad    = (HADDR[ADDR_WIDTH-1:2] >= DEPTH_LIM)
                 || (HSIZE > HSIZE_WORD)
                 || ((HSIZE == HSIZE_HALF) && HADDR[0])
                 || ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign take   = accept && ((state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2));

`ifdef AHB_SLAVE_WAIT_EN
    logic [CNT_W-1:0] wcnt;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wcnt <= '0;
        end else if ((state != ST_WAIT) && (state_nx == ST_WAIT)) begin
            wcnt <= CNT_W'(WAIT_CYCLES - 1);
        end else if ((state == ST_WAIT) && (wcnt != '0)) begin
            wcnt <= wcnt - 1'b1;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        rd_load  = 1'b0;
        rd_idx   = a_idx;
        fwd_hit  = 1'b0;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!take) begin
                    state_nx = ST_IDLE;
                end else if (bad) begin
                    state_nx = ST_ERR1;
                end else if (USE_WAIT) begin
                    state_nx = ST_WAIT;
                end else begin
                    state_nx = ST_DATA;
                    rd_load  = !HWRITE;
                    // Read landing on the word the current data phase is writing
                    fwd_hit  = !HWRITE && (state == ST_DATA) && d_write && (d_idx == a_idx);
                end
            end
`ifdef AHB_SLAVE_WAIT_EN
            ST_WAIT: begin
                if (wcnt == '0) begin
                    state_nx = ST_DATA;
                    rd_load  = !d_write;
                    rd_idx   = d_idx;
                end
            end
`endif
            ST_ERR1: state_nx = ST_ERR2;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            d_idx   <= '0;
            d_write <= 1'b0;
            d_size  <= HSIZE_BYTE;
            d_lo    <= 2'b00;
        end else if (take) begin
            d_idx   <= a_idx;
            d_write <= HWRITE;
            d_size  <= HSIZE;
            d_lo    <= HADDR[1:0];
        end
    end

    assign we = (state == ST_DATA) && d_write;
    assign be = lane_mask(d_size, d_lo);

    always_comb begin
        be_bits = '0;
        for (int b = 0; b < NLANES; b++) begin
            be_bits[8*b +: 8] = {8{be[b]}};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            fwd_mask <= '0;
            fwd_data <= '0;
        end else if (rd_load) begin
            fwd_mask <= fwd_hit ? be_bits : '0;
            fwd_data <= HWDATA;
        end
    end

    ahb_slave_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_WIDTH  (IDX_W)
    ) u_ram (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .we      (we),
        .be      (be),
        .waddr   (d_idx),
        .wdata   (HWDATA),
        .re      (rd_load),
        .raddr   (rd_idx),
        .rdata   (ram_q)
    );

    assign HRDATA    = (ram_q & ~fwd_mask) | (fwd_data & fwd_mask);
    assign hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
    assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed self-checking bench for ahb_slave_mem (SLAVE_ID=0, MEM_DEPTH=64);
// wait-state expectations follow AHB_SLAVE_WAIT_EN.
module tb_ahb_slave_mem;

`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [1:0]  HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] HRDATA;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the bus ready is this slave's ready
    assign HREADY = hreadyout;

    ahb_slave_mem #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .SLAVES_NUM  (4),
        .SLAVE_ID    (0),
        .MEM_DEPTH   (64),
        .WAIT_CYCLES (2)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .hreadyout (hreadyout),
        .hresp     (hresp),
        .HRDATA    (HRDATA)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Address phase for one cycle, then return 1ns into the following cycle
    task automatic start(input logic [1:0] sel, input logic [31:0] addr, input logic wr,
                         input logic [2:0] size, input logic [1:0] trans);
        HSEL   = sel;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        HTRANS = trans;
        tick();
        HTRANS = 2'b00;
    endtask

    task automatic finish(output int waits);
        waits = 0;
        while (hreadyout !== 1'b1 && waits < 20) begin
            tick();
            waits++;
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        HSEL = 2'd0; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'd2;
        HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'b00; HWDATA = '0;
        repeat (2) @(posedge HCLK);
        #1;
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL reset_hreadyout got %0b exp 1", hreadyout); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL reset_hresp got %0b exp 0", hresp); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL reset_hrdata got %h exp 00000000", HRDATA); end
        HRESETn = 1'b1;
        tick();
    endtask

    task automatic test_word_rw();
        int w;
        start(2'd0, 32'h10, 1'b1, 3'd2, 2'b10);
        HWDATA = 32'h12345678;
        finish(w);
        checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL word_wr_waits got %0d exp %0d", w, EXP_WAITS); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL word_wr_hresp got %0b exp 0", hresp); end
        tick();
        start(2'd0, 32'h10, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL word_rd_waits got %0d exp %0d", w, EXP_WAITS); end
        checks++; if (HRDATA !== 32'h12345678) begin errors++; $display("FAIL word_rd_data got %h exp 12345678", HRDATA); end
        checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL word_rd_hresp got %0b exp 0", hresp); end
        tick();
    endtask

    task automatic test_byte_half();
        int w;
        start(2'd0, 32'h21, 1'b1, 3'd0, 2'b10);
        HWDATA = 32'h0000AB00;
        finish(w);
        tick();
        start(2'd0, 32'h20, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'h0000AB00) begin errors++; $display("FAIL byte_rd_data got %h exp 0000ab00", HRDATA); end
        tick();
        start(2'd0, 32'h22, 1'b1, 3'd1, 2'b11);
        HWDATA = 32'hBEEF0000;
        finish(w);
        checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL half_wr_waits got %0d exp %0d", w, EXP_WAITS); end
        tick();
        start(2'd0, 32'h20, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'hBEEFAB00) begin errors++; $display("FAIL half_rd_data got %h exp beefab00", HRDATA); end
        tick();
    endtask

    task automatic test_errors();
        int w;
        // misaligned word read
        start(2'd0, 32'h102, 1'b0, 3'd2, 2'b10);
        checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL mis_rd_err1 got rdy=%0b resp=%0b exp rdy=0 resp=1", hreadyout, hresp); end
        checks++; if (HRDATA !== 32'hBEEFAB00) begin errors++; $display("FAIL mis_rd_hold got %h exp beefab00", HRDATA); end
        tick();
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin errors++; $display("FAIL mis_rd_err2 got rdy=%0b resp=%0b exp rdy=1 resp=1", hreadyout, hresp); end
        tick();
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL mis_rd_after got rdy=%0b resp=%0b exp rdy=1 resp=0", hreadyout, hresp); end
        // misaligned word write must not touch word 4
        start(2'd0, 32'h12, 1'b1, 3'd2, 2'b10);
        HWDATA = 32'hFFFFFFFF;
        checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL mis_wr_err1 got rdy=%0b resp=%0b exp rdy=0 resp=1", hreadyout, hresp); end
        tick();
        tick();
        start(2'd0, 32'h10, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'h12345678) begin errors++; $display("FAIL mis_wr_nochange got %h exp 12345678", HRDATA); end
        tick();
        // BUSY is not a transfer
        start(2'd0, 32'h0, 1'b0, 3'd2, 2'b01);
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0 || HRDATA !== 32'h12345678) begin errors++; $display("FAIL busy_noxfer got rdy=%0b resp=%0b data=%h exp rdy=1 resp=0 data=12345678", hreadyout, hresp, HRDATA); end
        tick();
        // index 64 out of range
        start(2'd0, 32'h100, 1'b0, 3'd2, 2'b10);
        checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL oor_err1 got rdy=%0b resp=%0b exp rdy=0 resp=1", hreadyout, hresp); end
        tick();
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b1) begin errors++; $display("FAIL oor_err2 got rdy=%0b resp=%0b exp rdy=1 resp=1", hreadyout, hresp); end
        tick();
        start(2'd0, 32'h0, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'h0 || hresp !== 1'b0) begin errors++; $display("FAIL after_oor_rd got data=%h resp=%0b exp data=00000000 resp=0", HRDATA, hresp); end
        tick();
        // HSIZE above word
        start(2'd0, 32'h0, 1'b0, 3'd3, 2'b10);
        checks++; if (hreadyout !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL size3_err1 got rdy=%0b resp=%0b exp rdy=0 resp=1", hreadyout, hresp); end
        tick();
        tick();
    endtask

    task automatic test_unselected();
        int w;
        start(2'd1, 32'h10, 1'b1, 3'd2, 2'b10);
        HWDATA = 32'hDEADBEEF;
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL unsel_resp got rdy=%0b resp=%0b exp rdy=1 resp=0", hreadyout, hresp); end
        tick();
        checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL unsel_rdy2 got %0b exp 1", hreadyout); end
        start(2'd0, 32'h10, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'h12345678) begin errors++; $display("FAIL unsel_nochange got %h exp 12345678", HRDATA); end
        tick();
    endtask

    task automatic test_back_to_back();
        int w;
        start(2'd0, 32'h8, 1'b1, 3'd2, 2'b10);
        HWDATA = 32'hCAFEF00D;
        HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8; HSIZE = 3'd2;
        finish(w);
        checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL b2b_wr_waits got %0d exp %0d", w, EXP_WAITS); end
        tick();
        HTRANS = 2'b00;
        finish(w);
        checks++; if (w !== EXP_WAITS) begin errors++; $display("FAIL b2b_rd_waits got %0d exp %0d", w, EXP_WAITS); end
        checks++; if (HRDATA !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_fwd_word got %h exp cafef00d", HRDATA); end
        tick();
        // partial lane forward
        start(2'd0, 32'h9, 1'b1, 3'd0, 2'b10);
        HWDATA = 32'h0000EE00;
        HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8; HSIZE = 3'd2;
        finish(w);
        tick();
        HTRANS = 2'b00;
        finish(w);
        checks++; if (HRDATA !== 32'hCAFEEE0D) begin errors++; $display("FAIL b2b_fwd_byte got %h exp cafeee0d", HRDATA); end
        tick();
        start(2'd0, 32'h8, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'hCAFEEE0D) begin errors++; $display("FAIL b2b_mem got %h exp cafeee0d", HRDATA); end
        tick();
    endtask

    task automatic test_reset_mid();
        int w;
        start(2'd0, 32'h30, 1'b1, 3'd2, 2'b10);
        HWDATA = 32'h55555555;
        #2;
        HRESETn = 1'b0;
        #1;
        checks++; if (hreadyout !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL rst_mid_resp got rdy=%0b resp=%0b exp rdy=1 resp=0", hreadyout, hresp); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_mid_data got %h exp 00000000", HRDATA); end
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        tick();
        start(2'd0, 32'h30, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_mid_dropped got %h exp 00000000", HRDATA); end
        tick();
        start(2'd0, 32'h10, 1'b0, 3'd2, 2'b10);
        finish(w);
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_mid_cleared got %h exp 00000000", HRDATA); end
        tick();
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_errors();
        test_unselected();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
